// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver (and later transmitter):
// frame geometry, FSM state encoding and the baud divider computation.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Clocks per oversample tick; truncating division.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable
// with clear so the sampling phase can be aligned to a detected edge.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; presents each good byte with a
// one-cycle uart_ready strobe and flags bad stop bits with frame_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx: CLK_FREQ too low for BAUD_RATE (DIV < 1)");
        end
    endgenerate

    state_t                 state, next_state;
    logic                   rx_meta, rx_s;
    logic                   tick, tick_clear;
    logic [3:0]             sample_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   cnt_clear, bit_clear, shift_en, data_load, stop_bad;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tick_clear = 1'b0;
        cnt_clear  = 1'b0;
        bit_clear  = 1'b0;
        shift_en   = 1'b0;
        data_load  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    next_state = START;
                    tick_clear = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a high line here means it was only a glitch.
                if (tick && sample_cnt == 4'd7) begin
                    if (!rx_s) begin
                        next_state = DATA;
                        cnt_clear  = 1'b1;
                        bit_clear  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && sample_cnt == 4'd15) begin
                    if (rx_s) begin
                        data_load  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
        end else begin
            if (cnt_clear) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end
            if (bit_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_data   <= '0;
            uart_ready  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            uart_ready  <= data_load;
            frame_error <= stop_bad;
            if (data_load) begin
                uart_data <= shift_reg;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver with 16x oversampling. Recovers bytes from the asynchronous serial line `rx`.
- Presents each good byte on `uart_data` with a one-cycle `uart_ready` strobe. This is exactly the byte/strobe pair the downstream LED display latches.
- Sits between the board RX pin and the display/consumer logic, in the same clock domain as the consumer.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bits/s.
- DIV (localparam), CLK_FREQ/(BAUD_RATE*16), clocks per oversample tick.
  - Integer division, truncated.
  - Elaboration error if DIV < 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- uart_data  output  8  last correctly framed byte; held until the next good frame.
- uart_ready  output  1  one-cycle pulse marking a new byte on uart_data.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - uart_data=8'h00, uart_ready=0, frame_error=0, busy=0.
  - State=IDLE; all counters cleared.
  - Synchroniser flops preset to 1, so no false start is seen on reset release.
  - Reset mid-frame abandons the frame with no strobe.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Tick generator:
  - Counter 0..DIV-1; `tick` is high for one cycle when the counter wraps.
  - Counter is cleared on entry to START, so sampling phase aligns to the detected edge.
- Sample counter: 4-bit, counts ticks within a bit and wraps at 15.
- State machine:
  - IDLE:
    - busy=0.
    - rx_s==0 → START; tick counter and sample counter cleared.
  - START:
    - On the 8th tick (mid-bit), sample rx_s.
    - rx_s==0 → DATA, sample counter and bit index cleared.
    - rx_s==1 → glitch; return to IDLE, no outputs touched.
  - DATA:
    - Every 16th tick, sample rx_s into a shift register, LSB first (bit 0 received first).
    - Bit index counts 0..7; after bit 7 is sampled → STOP.
  - STOP:
    - On the 16th tick, sample rx_s.
    - rx_s==1:
      - uart_data <= shift register and uart_ready=1 for exactly one cycle.
      - → IDLE.
    - rx_s==0:
      - frame_error=1 for one cycle; uart_data unchanged; no uart_ready.
      - → WAIT_HIGH.
  - WAIT_HIGH (break or line-held-low):
    - Stay while rx_s==0; rx_s==1 → IDLE.
    - Prevents a break condition from spawning repeated frames.
- Latency: uart_ready asserts one clock after the mid-stop-bit tick.
  - Nominally 2 + 8*DIV + 9*16*DIV clocks after the first clock rx is low (±1 cycle).
- Output exclusivity:
  - uart_ready and frame_error are never high together.
  - uart_ready never stays high 2 consecutive cycles.
- Back-to-back frames: a new start bit accepted in IDLE immediately after the STOP sample is received correctly. There is no required idle gap beyond the half stop bit.
- Consumer handshake: none. The consumer must capture on the pulse; an overrun is simply overwritten.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding constants: IDLE, START, DATA, STOP, WAIT_HIGH (3 bits).
  - DATA_BITS=8, OVERSAMPLE=16.
  - DIV computation function.
- One sub-module: `uart_baud_tick`.
  - Parameter DIV; ports clk, reset, clear, tick.
  - Reusable later by the transmitter.

Test Plan (CLK_FREQ=18_432_000, BAUD_RATE=115_200 → DIV=10, bit=160 clocks):
1. Send 8'hA5, stop=1.
   - uart_data==8'hA5 and a single-cycle uart_ready at 1522±2 clocks after the start edge.
   - frame_error stays 0.
2. Back-to-back 8'h00 then 8'hFF, no idle gap.
   - Two uart_ready pulses ~1600 clocks apart.
   - uart_data 8'h00 then 8'hFF.
3. 40-clock low glitch on idle rx.
   - Returns to IDLE after the mid-start sample; no uart_ready.
   - busy drops by clock ~85.
4. Send 8'h3C with stop bit low, then hold rx low for 2000 clocks, then release.
   - frame_error pulses once; uart_data keeps its previous value; no uart_ready.
   - No further strobes until rx is high and a new frame arrives.
5. Assert reset at data bit 4 of 8'h81, then send 8'h81 cleanly.
   - Outputs zero during reset; no strobe for the aborted frame.
   - Clean frame yields uart_data==8'h81.
6. Send 8'h55 at +3% baud skew (bit=155 clocks).
   - uart_data==8'h55, uart_ready asserted, frame_error 0.
